// File: rtl/jrb_regbank_pc.sv
// jrb_regbank_pc: general-purpose register bank, handshaked output register and program counter
//   Optional return stack is enabled by defining the macro RET_STACK_EN.
//   Ports:
//     clk, rst_n                     clock and asynchronous active-high reset (rst_n=1 resets)
//     en                             enables register-bank writes and PC updates
//     wr_en, wr_addr, wr_data        register-bank write port (wr_data also feeds the output register)
//     rd_a_addr/rd_a_data            combinational read port A
//     rd_b_addr/rd_b_data            combinational read port B
//     out_wr, out_data, out_valid,   output holding register with valid/ready handshake
//     out_ready, disp, out_overrun   display mirror and sticky dropped-write flag
//     pc_stall, pc_load, pc_call,    program counter controls, pc_stall has highest priority
//     pc_ret, pc_load_val, pc
//     stack_err                      sticky return-stack overflow/underflow (0 without RET_STACK_EN)
module jrb_regbank_pc #(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 4,
  localparam int AW         = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [AW-1:0]     rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              out_wr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] disp,
  output logic              out_overrun,
  input  logic              pc_stall,
  input  logic              pc_load,
  input  logic              pc_call,
  input  logic              pc_ret,
  input  logic [PC_W-1:0]   pc_load_val,
  output logic [PC_W-1:0]   pc,
  output logic              stack_err
);
  localparam logic [AW:0] NR = (AW+1)'(NUM_REGS);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [PC_W-1:0]   pc_inc;
  logic              xfer;
  logic              accept;
  // Addresses at or above NUM_REGS only exist when NUM_REGS is not a power of two.
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (en && wr_en && {1'b0, wr_addr} < NR) begin
      regs[wr_addr] <= wr_data;
    end
  always_comb begin
    rd_a_data = {1'b0, rd_a_addr} < NR ? regs[rd_a_addr] : '0;
    rd_b_data = {1'b0, rd_b_addr} < NR ? regs[rd_b_addr] : '0;
  end
  // A transfer frees the holding register in the same cycle, so a new write can land without a bubble.
  assign xfer   = out_valid && out_ready;
  assign accept = out_wr && (!out_valid || xfer);
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      out_data    <= '0;
      disp        <= '0;
      out_valid   <= 1'b0;
      out_overrun <= 1'b0;
    end else begin
      if (accept) begin
        out_data  <= wr_data;
        disp      <= wr_data;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (out_wr && !accept) out_overrun <= 1'b1;
    end
  assign pc_inc = pc + 1'b1;
`ifdef RET_STACK_EN
  localparam int SW  = $clog2(STACK_DEPTH + 1);
  localparam int SIW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SW-1:0] SD = SW'(STACK_DEPTH);
  logic [PC_W-1:0] stk [STACK_DEPTH];
  logic [SW-1:0]   sp;
  logic [SW-1:0]   sp_dec;
  assign sp_dec = sp - 1'b1;
  // sp counts occupied entries; the top of stack lives at sp-1.
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      pc        <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
    end else if (en && !pc_stall) begin
      if (pc_call) begin
        pc <= pc_load_val;
        if (sp != SD) begin
          stk[sp[SIW-1:0]] <= pc_inc;
          sp               <= sp + 1'b1;
        end else begin
          stack_err <= 1'b1;
        end
      end else if (pc_ret) begin
        if (sp != '0) begin
          pc <= stk[sp_dec[SIW-1:0]];
          sp <= sp_dec;
        end else begin
          pc        <= pc_inc;
          stack_err <= 1'b1;
        end
      end else begin
        pc <= pc_load ? pc_load_val : pc_inc;
      end
    end
`else
  logic unused_ret;
  assign unused_ret = pc_ret ^ (STACK_DEPTH == 0);
  assign stack_err  = 1'b0;
  // Without a stack, a call is just a jump and a return is an ordinary step.
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) pc <= '0;
    else if (en && !pc_stall) pc <= (pc_call || pc_load) ? pc_load_val : pc_inc;
`endif
endmodule

// File: tb/tb_jrb_regbank_pc.sv
// tb_jrb_regbank_pc: directed self-checking bench for jrb_regbank_pc
module tb_jrb_regbank_pc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [1:0]  rd_a_addr = '0;
  logic [7:0]  rd_a_data;
  logic [1:0]  rd_b_addr = '0;
  logic [7:0]  rd_b_data;
  logic        out_wr = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  disp;
  logic        out_overrun;
  logic        pc_stall = 1'b0;
  logic        pc_load = 1'b0;
  logic        pc_call = 1'b0;
  logic        pc_ret = 1'b0;
  logic [15:0] pc_load_val = '0;
  logic [15:0] pc;
  logic        stack_err;
  int n_cmp = 0;
  int n_err = 0;

  jrb_regbank_pc dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .out_wr(out_wr), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .disp(disp), .out_overrun(out_overrun), .pc_stall(pc_stall), .pc_load(pc_load),
    .pc_call(pc_call), .pc_ret(pc_ret), .pc_load_val(pc_load_val), .pc(pc), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b0;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_disp", disp, 8'h00);
    chk("rst_overrun", out_overrun, 1'b0);
    chk("rst_stack_err", stack_err, 1'b0);
    chk("rst_reg0", rd_a_data, 8'h00);

    en = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5; rd_a_addr = 2'd2; rd_b_addr = 2'd2;
    #1;
    chk("no_bypass_a", rd_a_data, 8'h00);
    tick();
    chk("wr2_a", rd_a_data, 8'hA5);
    chk("wr2_b", rd_b_data, 8'hA5);
    wr_addr = 2'd1; wr_data = 8'h11;
    tick();
    wr_addr = 2'd3; wr_data = 8'h33;
    tick();
    en = 1'b0; wr_addr = 2'd1; wr_data = 8'hFF; rd_a_addr = 2'd1; rd_b_addr = 2'd3;
    tick();
    chk("en0_hold_r1", rd_a_data, 8'h11);
    chk("wr3_b", rd_b_data, 8'h33);
    wr_en = 1'b0;

    out_wr = 1'b1; wr_data = 8'h3C;
    tick();
    chk("out1_valid", out_valid, 1'b1);
    chk("out1_disp", disp, 8'h3C);
    chk("out1_data", out_data, 8'h3C);
    wr_data = 8'h77;
    tick();
    chk("ovr_data", out_data, 8'h3C);
    chk("ovr_flag", out_overrun, 1'b1);
    chk("ovr_disp", disp, 8'h3C);
    out_ready = 1'b1; wr_data = 8'h55;
    tick();
    chk("zb_data", out_data, 8'h55);
    chk("zb_valid", out_valid, 1'b1);
    chk("zb_disp", disp, 8'h55);
    out_wr = 1'b0;
    tick();
    chk("drain_valid", out_valid, 1'b0);
    chk("overrun_sticky", out_overrun, 1'b1);
    out_ready = 1'b0;

    en = 1'b1; pc_load = 1'b1; pc_load_val = 16'hFFFE;
    tick();
    chk("pc_load_fffe", pc, 16'hFFFE);
    pc_load = 1'b0;
    tick();
    chk("pc_ffff", pc, 16'hFFFF);
    tick();
    chk("pc_wrap", pc, 16'h0000);
    pc_stall = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0100;
    tick();
    chk("pc_stall", pc, 16'h0000);
    pc_stall = 1'b0;
    tick();
    chk("pc_unstall_load", pc, 16'h0100);
    pc_load = 1'b0; en = 1'b0;
    tick();
    chk("pc_en0_hold", pc, 16'h0100);
    en = 1'b1;

`ifdef RET_STACK_EN
    pc_load = 1'b1; pc_load_val = 16'h0010;
    tick();
    pc_load = 1'b0; pc_call = 1'b1; pc_load_val = 16'h0200;
    tick();
    chk("call_pc", pc, 16'h0200);
    pc_call = 1'b0; pc_ret = 1'b1;
    tick();
    chk("ret_pc", pc, 16'h0011);
    pc_ret = 1'b0; pc_call = 1'b1;
    pc_load_val = 16'h0A00; tick();
    pc_load_val = 16'h0B00; tick();
    pc_load_val = 16'h0C00; tick();
    pc_load_val = 16'h0D00; tick();
    chk("call4_pc", pc, 16'h0D00);
    chk("call4_noerr", stack_err, 1'b0);
    pc_load_val = 16'h0E00; tick();
    chk("call5_pc", pc, 16'h0E00);
    chk("call5_err", stack_err, 1'b1);
    pc_call = 1'b0; pc_ret = 1'b1;
    tick(); chk("pop1", pc, 16'h0C01);
    tick(); chk("pop2", pc, 16'h0B01);
    tick(); chk("pop3", pc, 16'h0A01);
    tick(); chk("pop4", pc, 16'h0012);
    tick(); chk("pop_empty_pc", pc, 16'h0013);
    chk("pop_empty_err", stack_err, 1'b1);
    pc_call = 1'b1; pc_load_val = 16'h0F00;
    tick();
    chk("call_wins", pc, 16'h0F00);
    pc_call = 1'b0;
    tick();
    chk("ret_after_both", pc, 16'h0014);
    pc_ret = 1'b0;
`else
    pc_call = 1'b1; pc_load_val = 16'h0300;
    tick();
    chk("call_as_load", pc, 16'h0300);
    pc_call = 1'b0; pc_ret = 1'b1;
    tick();
    chk("ret_ignored", pc, 16'h0301);
    chk("no_stack_err", stack_err, 1'b0);
    pc_ret = 1'b0;
`endif

    pc_load = 1'b1; pc_load_val = 16'h1234; out_wr = 1'b1; wr_data = 8'h9C;
    tick();
    pc_load = 1'b0; en = 1'b0; out_wr = 1'b0; rd_a_addr = 2'd2; rd_b_addr = 2'd1;
    chk("pre_rst_pc", pc, 16'h1234);
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_reg2", rd_a_data, 8'hA5);
    #2;
    rst_n = 1'b1;
    #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_reg2", rd_a_data, 8'h00);
    chk("arst_reg1", rd_b_data, 8'h00);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_disp", disp, 8'h00);
    chk("arst_overrun", out_overrun, 1'b0);
    chk("arst_stack_err", stack_err, 1'b0);
    tick();
    rst_n = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
